hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 167 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard unit for a 5-stage pipeline with a multi-cycle multiply/divide
//   unit (MDU). It produces the forwarding selects for D and E, the
//   load-use and branch stalls, and holds E for MDU_LAT cycles per MDU op.
//
// Parameters
//   AW      register-specifier width
//   MDU_LAT total stall cycles per MDU op (>= 2)
//   CNT_W   width of each performance counter
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   rsD, rtD, rsE, rtE            source specifiers in D and E
//   writeregE/M/W                 destination specifiers in E, M, W
//   regwriteE/M/W, mem2regE/M     writeback / load flags per stage
//   branchD                       branch compare in D
//   mdustartE                     MDU op occupying E
//   forwardaD, forwardbD          D-stage compare takes the M result
//   forwardaE, forwardbE          00 regfile, 01 W, 10 M
//   stallF, stallD, stallE        pipeline holds
//   flushE, flushM                bubble insertion
//   mdubusy, mdudone              MDU stalling / final one-cycle pulse
//   cnt_lw, cnt_br, cnt_mdu       saturating stall-cycle counters
//
// Configuration
//   HAZARD_PERF_CNT_EN  when defined, the stall counters are implemented;
//                       otherwise they read constant 0 and use no flops.
module hazard_scoreboard #(
  parameter int AW      = 5,
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rsD,
  input  logic [AW-1:0]    rtD,
  input  logic [AW-1:0]    rsE,
  input  logic [AW-1:0]    rtE,
  input  logic [AW-1:0]    writeregE,
  input  logic [AW-1:0]    writeregM,
  input  logic [AW-1:0]    writeregW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             mem2regE,
  input  logic             mem2regM,
  input  logic             branchD,
  input  logic             mdustartE,
  output logic             forwardaD,
  output logic             forwardbD,
  output logic [1:0]       forwardaE,
  output logic [1:0]       forwardbE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             flushE,
  output logic             flushM,
  output logic             mdubusy,
  output logic             mdudone,
  output logic [CNT_W-1:0] cnt_lw,
  output logic [CNT_W-1:0] cnt_br,
  output logic [CNT_W-1:0] cnt_mdu
);

  // Down-counter just wide enough to hold MDU_LAT-1.
  localparam int            CW       = $clog2(MDU_LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LAT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_t;

  mdu_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          lwstall, brstall, mdustall;

  // Forwarding: register 0 is never forwarded; M wins over W.
  assign forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
  assign forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the if/case chain can infer a latch.
    forwardaE = 2'b00;
    forwardbE = 2'b00;
    if (rsE != '0 && rsE == writeregM && regwriteM)      forwardaE = 2'b10;
    else if (rsE != '0 && rsE == writeregW && regwriteW) forwardaE = 2'b01;
    if (rtE != '0 && rtE == writeregM && regwriteM)      forwardbE = 2'b10;
    else if (rtE != '0 && rtE == writeregW && regwriteW) forwardbE = 2'b01;
  end

  assign lwstall = mem2regE && (rtE != '0) && ((rtE == rsD) || (rtE == rtD));

  assign brstall = branchD &&
    ((regwriteE && (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD))) ||
     (mem2regM  && (writeregM != '0) && ((writeregM == rsD) || (writeregM == rtD))));

  // MDU sequencer: the IDLE cycle that sees mdustartE already stalls, then
  // BUSY covers the remaining MDU_LAT-1 cycles, then a single DONE cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mdustall  = 1'b0;
    mdudone   = 1'b0;
    case (state)
      IDLE: begin
        if (mdustartE) begin
          mdustall  = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        mdustall = 1'b1;
        cnt_nxt  = cnt - CW'(1);
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        mdudone   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mdubusy = mdustall;
  assign stallF  = lwstall | brstall | mdustall;
  assign stallD  = stallF;
  assign stallE  = mdustall;
  assign flushM  = mdustall;
  // E is held during an MDU op, so it must not also be bubbled.
  assign flushE  = (lwstall | brstall) & ~mdustall;

`ifdef HAZARD_PERF_CNT_EN
  // A branch stall hidden under a load-use stall counts only as load-use;
  // anything under an MDU stall counts only as MDU.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_lw  <= '0;
      cnt_br  <= '0;
      cnt_mdu <= '0;
    end else begin
      if (lwstall && !mdustall && cnt_lw != '1)
        cnt_lw <= cnt_lw + CNT_W'(1);
      if (brstall && !lwstall && !mdustall && cnt_br != '1)
        cnt_br <= cnt_br + CNT_W'(1);
      if (mdustall && cnt_mdu != '1)
        cnt_mdu <= cnt_mdu + CNT_W'(1);
    end
  end
`else
  assign cnt_lw  = '0;
  assign cnt_br  = '0;
  assign cnt_mdu = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Self-checking bench for hazard_scoreboard (MDU_LAT=4, CNT_W=3).
//   Directed scenarios first, then randomized traffic; every cycle all
//   outputs are compared against a behavioural model that tracks the MDU
//   op as "stall cycles left" plus a pending-done flag.
//   Honours HAZARD_PERF_CNT_EN the same way the design does.
module tb_hazard_scoreboard;
  localparam int AW      = 5;
  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAZARD_PERF_CNT_EN
  localparam int LW_SAT  = 7;
`else
  localparam int LW_SAT  = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [AW-1:0]    rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic             regwriteE, regwriteM, regwriteW, mem2regE, mem2regM;
  logic             branchD, mdustartE;
  logic             forwardaD, forwardbD;
  logic [1:0]       forwardaE, forwardbE;
  logic             stallF, stallD, stallE, flushE, flushM, mdubusy, mdudone;
  logic [CNT_W-1:0] cnt_lw, cnt_br, cnt_mdu;

  hazard_scoreboard #(.AW(AW), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .mem2regE(mem2regE), .mem2regM(mem2regM),
    .branchD(branchD), .mdustartE(mdustartE),
    .forwardaD(forwardaD), .forwardbD(forwardbD),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushE(flushE), .flushM(flushM),
    .mdubusy(mdubusy), .mdudone(mdudone),
    .cnt_lw(cnt_lw), .cnt_br(cnt_br), .cnt_mdu(cnt_mdu)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_left;   // MDU stall cycles still to come after the start cycle
  bit m_done;   // next cycle is the one-cycle completion pulse
  int m_lw, m_br, m_mdu;

  function automatic bit hit(input logic [AW-1:0] src, input logic [AW-1:0] dst, input logic we);
    return we && (src != 0) && (src == dst);
  endfunction

  function automatic int fwd_e(input logic [AW-1:0] src);
    if (hit(src, writeregM, regwriteM)) return 2;
    if (hit(src, writeregW, regwriteW)) return 1;
    return 0;
  endfunction

  function automatic bit m_lwstall();
    return mem2regE && (rtE != 0) && (rtE == rsD || rtE == rtD);
  endfunction

  function automatic bit m_brstall();
    return branchD && (hit(rsD, writeregE, regwriteE) || hit(rtD, writeregE, regwriteE) ||
                       hit(rsD, writeregM, mem2regM)  || hit(rtD, writeregM, mem2regM));
  endfunction

  function automatic bit m_mdustall();
    return (m_left > 0) || (!m_done && mdustartE);
  endfunction

  task automatic model_reset();
    m_left = 0; m_done = 0; m_lw = 0; m_br = 0; m_mdu = 0;
  endtask

  task automatic model_step();
    bit lw, br, ms;
    if (rst) begin
      model_reset();
    end else begin
      lw = m_lwstall(); br = m_brstall(); ms = m_mdustall();
`ifdef HAZARD_PERF_CNT_EN
      if (lw && !ms && m_lw < CNT_MAX)        m_lw++;
      if (br && !lw && !ms && m_br < CNT_MAX) m_br++;
      if (ms && m_mdu < CNT_MAX)              m_mdu++;
`endif
      if (m_done) m_done = 0;
      else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_done = 1;
      end else if (mdustartE) m_left = MDU_LAT - 1;
    end
  endtask

  task automatic check_all();
    bit lw, br, ms;
    lw = m_lwstall(); br = m_brstall(); ms = m_mdustall();
    check("forwardaD", 32'(forwardaD), 32'(hit(rsD, writeregM, regwriteM)));
    check("forwardbD", 32'(forwardbD), 32'(hit(rtD, writeregM, regwriteM)));
    check("forwardaE", 32'(forwardaE), fwd_e(rsE));
    check("forwardbE", 32'(forwardbE), fwd_e(rtE));
    check("stallF",    32'(stallF),    32'(lw || br || ms));
    check("stallD",    32'(stallD),    32'(lw || br || ms));
    check("stallE",    32'(stallE),    32'(ms));
    check("flushM",    32'(flushM),    32'(ms));
    check("flushE",    32'(flushE),    32'((lw || br) && !ms));
    check("mdubusy",   32'(mdubusy),   32'(ms));
    check("mdudone",   32'(mdudone),   32'(m_done));
    check("cnt_lw",    32'(cnt_lw),    m_lw);
    check("cnt_br",    32'(cnt_br),    m_br);
    check("cnt_mdu",   32'(cnt_mdu),   m_mdu);
  endtask

  // Outputs are compared at the falling edge; the model advances at the
  // rising edge; inputs change 1 time unit after the rising edge.
  task automatic sample();
    @(negedge clk);
    check_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic quiet();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    writeregE = '0; writeregM = '0; writeregW = '0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    mem2regE = 0; mem2regM = 0; branchD = 0; mdustartE = 0;
  endtask

  initial begin
    quiet();
    rst = 1;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    // Reset state, still in reset.
    sample();
    check("rst_mdubusy", 32'(mdubusy), 0);
    check("rst_stallE",  32'(stallE),  0);
    check("rst_cnt_mdu", 32'(cnt_mdu), 0);
    advance();
    rst = 0;

    // Load-use.
    mem2regE = 1; rtE = 5'd8; rsD = 5'd8;
    sample();
    check("lu_stallF", 32'(stallF), 1);
    check("lu_stallD", 32'(stallD), 1);
    check("lu_flushE", 32'(flushE), 1);
    check("lu_stallE", 32'(stallE), 0);
    advance();
    rtE = 5'd0; rsD = 5'd0;
    sample();
    check("lu0_stallF", 32'(stallF), 0);
    advance();
    quiet();

    // Forwarding priority.
    rsE = 5'd3; writeregM = 5'd3; writeregW = 5'd3; regwriteM = 1; regwriteW = 1;
    sample(); check("fwd_m", 32'(forwardaE), 2); advance();
    regwriteM = 0;
    sample(); check("fwd_w", 32'(forwardaE), 1); advance();
    rsE = 5'd0;
    sample(); check("fwd_rf", 32'(forwardaE), 0); advance();
    quiet();

    // MDU op with start held high through DONE.
    mdustartE = 1;
    for (int i = 0; i < MDU_LAT; i++) begin
      sample();
      check("mdu_stallE", 32'(stallE), 1);
      check("mdu_flushM", 32'(flushM), 1);
      check("mdu_flushE", 32'(flushE), 0);
      check("mdu_nodone", 32'(mdudone), 0);
      advance();
    end
    sample();
    check("mdu_done",      32'(mdudone), 1);
    check("mdu_done_stall", 32'(stallF), 0);
    advance();
    mdustartE = 0;
    sample(); check("mdu_idle", 32'(mdubusy), 0); advance();

    // Branch stall overlapping an MDU op.
    mdustartE = 1;
    tick();
    mdustartE = 0; branchD = 1; regwriteE = 1; writeregE = 5'd5; rsD = 5'd5;
    for (int i = 1; i < MDU_LAT; i++) begin
      sample();
      check("ovl_flushE", 32'(flushE), 0);
      check("ovl_stallD", 32'(stallD), 1);
      advance();
    end
    sample(); check("ovl_done_flushE", 32'(flushE), 1); advance();
    sample(); check("ovl_idle_flushE", 32'(flushE), 1); advance();
    quiet();

    // Reset in the second BUSY cycle.
    mdustartE = 1;
    tick();
    tick();
    rst = 1; mdustartE = 0;
    tick();
    rst = 0;
    sample();
    check("rmid_mdubusy", 32'(mdubusy), 0);
    check("rmid_cnt_lw",  32'(cnt_lw),  0);
    check("rmid_cnt_mdu", 32'(cnt_mdu), 0);
    advance();
    for (int i = 0; i < 6; i++) begin
      sample(); check("rmid_nodone", 32'(mdudone), 0); advance();
    end

    // Counter saturation: 10 load-use cycles from a fresh counter.
    mem2regE = 1; rtE = 5'd8; rsD = 5'd8;
    repeat (10) tick();
    sample(); check("lw_sat", 32'(cnt_lw), LW_SAT); advance();
    quiet();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rsD = AW'($urandom_range(0, 3)); rtD = AW'($urandom_range(0, 3));
      rsE = AW'($urandom_range(0, 3)); rtE = AW'($urandom_range(0, 3));
      writeregE = AW'($urandom_range(0, 3));
      writeregM = AW'($urandom_range(0, 3));
      writeregW = AW'($urandom_range(0, 3));
      regwriteE = 1'($urandom); regwriteM = 1'($urandom); regwriteW = 1'($urandom);
      mem2regE  = 1'($urandom); mem2regM  = 1'($urandom); branchD   = 1'($urandom);
      mdustartE = ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
